id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  clock, rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ID inputs: id_valid in 1; rs, rt, rd in 5 each; use_rs, use_rt in 1 each (operand actually read); qa, qb in 32 each (register-file read data); imm in 32; regrt in 1 (dest = rt when 1, else rd).
REQ-003 SHALL have ID control inputs: wreg in 1; m2reg in 1; wmem in 1; aluc in 4; aluimm in 1.
REQ-004 SHALL have hazard inputs: ex_wreg, ex_m2reg in 1, ex_wn in 5, ex_alu in 32; mem_wreg, mem_m2reg in 1, mem_wn in 5, mem_alu, mem_mdo in 32; wb_wreg in 1, wb_wn in 5, wb_d in 32; flush in 1 (branch/jump kill).
REQ-005 SHALL have outputs: e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm out 1; e_aluc out 4; e_a, e_b, e_imm out 32; e_wn out 5; stall out 1 (hold PC and IF/ID); stall_cnt out 16.

Function
REQ-006 Forwarded operand A SHALL select, by priority: ex_alu if ex_wreg & ~ex_m2reg & ex_wn==rs; else mem_alu if mem_wreg & ~mem_m2reg & mem_wn==rs; else mem_mdo if mem_wreg & mem_m2reg & mem_wn==rs; else wb_d if wb_wreg & wb_wn==rs; else qa.
REQ-007 Operand B SHALL use the identical rule with rt and qb.
REQ-008 No forwarding SHALL occur when the source register index is 0; operand SHALL be qa/qb (already 0).
REQ-009 stall SHALL be combinational: id_valid & ~flush & ex_wreg & ex_m2reg & ex_wn!=0 & ((use_rs & ex_wn==rs) | (use_rt & ex_wn==rt)).
REQ-010 On each rising edge with flush=1 or stall=1 or id_valid=0, ID/EX SHALL load a bubble: e_valid, e_wreg, e_m2reg, e_wmem = 0; datapath fields unspecified but deterministic (loaded as normal).
REQ-011 Otherwise ID/EX SHALL load e_valid=1, control inputs, forwarded A/B, imm, e_wn = regrt ? rt : rd; latency ID->E outputs one cycle.
REQ-012 flush SHALL take priority over stall; stall SHALL be 0 whenever flush=1.
REQ-013 stall_cnt SHALL increment by 1 on each rising edge with stall=1, saturating at 16'hFFFF.
REQ-014 A load-use stall SHALL last exactly one cycle: next cycle the load is in MEM and REQ-006 selects mem_mdo.
REQ-015 Write to index 0 in any stage SHALL never be forwarded or cause stall.

Reset
REQ-016 While rst_n=0, all ID/EX outputs and stall_cnt SHALL be 0 asynchronously; e_valid=0 (bubble).
REQ-017 stall SHALL depend only on inputs, unaffected by reset beyond registered state.
REQ-018 Reset deassertion SHALL take effect at the next rising clk; first loaded stage follows REQ-010/011.

Structure
REQ-019 Shared package cpu_pkg SHALL hold: ALUC_W=4, REG_IDX_W=5, XLEN=32, forwarding-select encodings (FWD_RF, FWD_EX, FWD_MEM_ALU, FWD_MEM_MDO, FWD_WB), bubble control constant.
REQ-020 Sub-module fwd_mux SHALL implement REQ-006 for one operand; id_ex_stage SHALL instantiate it twice.
REQ-021 Pipeline register, stall logic and stall_cnt SHALL reside in id_ex_stage.

Verification
REQ-022 Reset mid-run with e_wreg=1, stall_cnt=5 -> all outputs 0 immediately, before next clk edge.
REQ-023 ex_wreg=1, ex_m2reg=0, ex_wn=3, ex_alu=0x11, mem same reg mem_alu=0x22, rs=3 -> e_a=0x11 after edge (EX priority).
REQ-024 Load in EX ex_wn=5, rt=5, use_rt=1 -> stall=1 one cycle, bubble e_valid=0, stall_cnt=1; next cycle mem_mdo=0xDEAD -> e_b=0xDEAD, e_valid=1.
REQ-025 Same load-use with flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
REQ-026 rs=0, ex_wn=0, ex_wreg=1, ex_alu=0x55 -> e_a=0, stall=0; wb_wn=7, wb_d=0x77, rt=7 -> e_b=0x77.
REQ-027 Force stall continuously 70000 cycles -> stall_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ID/EX pipeline slice.
// Contents: datapath widths, forwarding-select encodings, the ID/EX control
// bundle and the bubble control constant. There are no ports; other files
// use these definitions through import cpu_pkg::*.
package cpu_pkg;

  localparam int unsigned ALUC_W      = 4;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned STALL_CNT_W = 16;

  // Operand source chosen by the forwarding network.
  typedef enum logic [2:0] {
    FWD_RF      = 3'd0,
    FWD_EX      = 3'd1,
    FWD_MEM_ALU = 3'd2,
    FWD_MEM_MDO = 3'd3,
    FWD_WB      = 3'd4
  } fwd_sel_e;

  // Control fields carried from ID into EX.
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, aluimm: 1'b0,
                                    aluc: '0};

  // A bubble only clears the side-effecting controls. aluc/aluimm flow through
  // unchanged so the datapath stays deterministic.
  function automatic ctrl_t kill_ctrl(input ctrl_t c);
    ctrl_t r;
    r       = c;
    r.wreg  = CTRL_BUBBLE.wreg;
    r.m2reg = CTRL_BUBBLE.m2reg;
    r.wmem  = CTRL_BUBBLE.wmem;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the ID stage and the ID/EX pipeline register.
// Signals: the ID operands and controls, the hazard and forwarding inputs from
// EX/MEM/WB, the registered E-stage outputs, and the stall signals.
// Modports: master (ID side and test driver) and slave (id_ex_stage).
interface id_ex_stage_if;
  import cpu_pkg::*;

  // ID operands and control
  logic                 id_valid;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic                 use_rs, use_rt;
  logic [XLEN-1:0]      qa, qb, imm;
  logic                 regrt;
  logic                 wreg, m2reg, wmem, aluimm;
  logic [ALUC_W-1:0]    aluc;

  // Later-stage state used for hazards and forwarding
  logic                 ex_wreg, ex_m2reg;
  logic [REG_IDX_W-1:0] ex_wn;
  logic [XLEN-1:0]      ex_alu;
  logic                 mem_wreg, mem_m2reg;
  logic [REG_IDX_W-1:0] mem_wn;
  logic [XLEN-1:0]      mem_alu, mem_mdo;
  logic                 wb_wreg;
  logic [REG_IDX_W-1:0] wb_wn;
  logic [XLEN-1:0]      wb_d;
  logic                 flush;

  // E-stage outputs
  logic                   e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm;
  logic [ALUC_W-1:0]      e_aluc;
  logic [XLEN-1:0]        e_a, e_b, e_imm;
  logic [REG_IDX_W-1:0]   e_wn;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, rs, rt, rd, use_rs, use_rt, qa, qb, imm, regrt,
           wreg, m2reg, wmem, aluimm, aluc,
           ex_wreg, ex_m2reg, ex_wn, ex_alu,
           mem_wreg, mem_m2reg, mem_wn, mem_alu, mem_mdo,
           wb_wreg, wb_wn, wb_d, flush,
    input  e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc,
           e_a, e_b, e_imm, e_wn, stall, stall_cnt
  );

  modport slave (
    input  id_valid, rs, rt, rd, use_rs, use_rt, qa, qb, imm, regrt,
           wreg, m2reg, wmem, aluimm, aluc,
           ex_wreg, ex_m2reg, ex_wn, ex_alu,
           mem_wreg, mem_m2reg, mem_wn, mem_alu, mem_mdo,
           wb_wreg, wb_wn, wb_d, flush,
    output e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc,
           e_a, e_b, e_imm, e_wn, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_mux.sv
// Forwarding mux for one source operand. Picks the youngest producer of the
// source register: EX ALU result, then MEM ALU result, then MEM load data,
// then WB data, and falls back to the register-file read.
// Ports: src_i (source index), rf_data_i (register-file data), ex_*/mem_*/wb_*
// (producer write-enable, load flag, destination and data), data_o (operand).
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic [XLEN-1:0]      rf_data_i,
  input  logic                 ex_wreg_i,
  input  logic                 ex_m2reg_i,
  input  logic [REG_IDX_W-1:0] ex_wn_i,
  input  logic [XLEN-1:0]      ex_alu_i,
  input  logic                 mem_wreg_i,
  input  logic                 mem_m2reg_i,
  input  logic [REG_IDX_W-1:0] mem_wn_i,
  input  logic [XLEN-1:0]      mem_alu_i,
  input  logic [XLEN-1:0]      mem_mdo_i,
  input  logic                 wb_wreg_i,
  input  logic [REG_IDX_W-1:0] wb_wn_i,
  input  logic [XLEN-1:0]      wb_d_i,
  output logic [XLEN-1:0]      data_o
);

  fwd_sel_e sel;

  // r0 is hardwired zero, so a matching write to index 0 is never forwarded.
  // A load still in EX has no data yet; the stall logic covers that case.
  always_comb begin
    sel = FWD_RF;
    if (src_i != '0) begin
      if (ex_wreg_i && !ex_m2reg_i && (ex_wn_i == src_i)) begin
        sel = FWD_EX;
      end else if (mem_wreg_i && !mem_m2reg_i && (mem_wn_i == src_i)) begin
        sel = FWD_MEM_ALU;
      end else if (mem_wreg_i && mem_m2reg_i && (mem_wn_i == src_i)) begin
        sel = FWD_MEM_MDO;
      end else if (wb_wreg_i && (wb_wn_i == src_i)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_EX:      data_o = ex_alu_i;
      FWD_MEM_ALU: data_o = mem_alu_i;
      FWD_MEM_MDO: data_o = mem_mdo_i;
      FWD_WB:      data_o = wb_d_i;
      default:     data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding, load-use stall detection, the
// ID/EX pipeline register and a saturating stall counter.
// Ports: clk (rising edge), rst_n (asynchronous, active low),
// bus_io (id_ex_stage_if.slave: ID inputs, hazard inputs, E outputs, stall).
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus_io
);

  logic [XLEN-1:0] fwd_a, fwd_b;

  fwd_mux u_fwd_a (
    .src_i       (bus_io.rs),
    .rf_data_i   (bus_io.qa),
    .ex_wreg_i   (bus_io.ex_wreg),
    .ex_m2reg_i  (bus_io.ex_m2reg),
    .ex_wn_i     (bus_io.ex_wn),
    .ex_alu_i    (bus_io.ex_alu),
    .mem_wreg_i  (bus_io.mem_wreg),
    .mem_m2reg_i (bus_io.mem_m2reg),
    .mem_wn_i    (bus_io.mem_wn),
    .mem_alu_i   (bus_io.mem_alu),
    .mem_mdo_i   (bus_io.mem_mdo),
    .wb_wreg_i   (bus_io.wb_wreg),
    .wb_wn_i     (bus_io.wb_wn),
    .wb_d_i      (bus_io.wb_d),
    .data_o      (fwd_a)
  );

  fwd_mux u_fwd_b (
    .src_i       (bus_io.rt),
    .rf_data_i   (bus_io.qb),
    .ex_wreg_i   (bus_io.ex_wreg),
    .ex_m2reg_i  (bus_io.ex_m2reg),
    .ex_wn_i     (bus_io.ex_wn),
    .ex_alu_i    (bus_io.ex_alu),
    .mem_wreg_i  (bus_io.mem_wreg),
    .mem_m2reg_i (bus_io.mem_m2reg),
    .mem_wn_i    (bus_io.mem_wn),
    .mem_alu_i   (bus_io.mem_alu),
    .mem_mdo_i   (bus_io.mem_mdo),
    .wb_wreg_i   (bus_io.wb_wreg),
    .wb_wn_i     (bus_io.wb_wn),
    .wb_d_i      (bus_io.wb_d),
    .data_o      (fwd_b)
  );

  // Load in EX whose destination is read by the instruction in ID. Purely
  // combinational; a flush kills the ID instruction, so no stall is needed.
  logic ld_hit_rs, ld_hit_rt, stall;

  always_comb begin
    ld_hit_rs = bus_io.use_rs && (bus_io.ex_wn == bus_io.rs);
    ld_hit_rt = bus_io.use_rt && (bus_io.ex_wn == bus_io.rt);
    stall     = bus_io.id_valid && !bus_io.flush && bus_io.ex_wreg && bus_io.ex_m2reg &&
                (bus_io.ex_wn != '0) && (ld_hit_rs || ld_hit_rt);
  end

  // Pipeline register
  ctrl_t                  ctrl_in, ctrl_d, ctrl_q;
  logic                   valid_d, valid_q;
  logic [XLEN-1:0]        a_d, a_q, b_d, b_q, imm_d, imm_q;
  logic [REG_IDX_W-1:0]   wn_d, wn_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic                   bubble;

  always_comb begin
    ctrl_in = '{wreg: bus_io.wreg, m2reg: bus_io.m2reg, wmem: bus_io.wmem,
                aluimm: bus_io.aluimm, aluc: bus_io.aluc};
    bubble  = bus_io.flush || stall || !bus_io.id_valid;
    valid_d = !bubble;
    ctrl_d  = bubble ? kill_ctrl(ctrl_in) : ctrl_in;
    a_d     = fwd_a;
    b_d     = fwd_b;
    imm_d   = bus_io.imm;
    wn_d    = bus_io.regrt ? bus_io.rt : bus_io.rd;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      wn_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      wn_q        <= wn_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_io.e_valid   = valid_q;
  assign bus_io.e_wreg    = ctrl_q.wreg;
  assign bus_io.e_m2reg   = ctrl_q.m2reg;
  assign bus_io.e_wmem    = ctrl_q.wmem;
  assign bus_io.e_aluimm  = ctrl_q.aluimm;
  assign bus_io.e_aluc    = ctrl_q.aluc;
  assign bus_io.e_a       = a_q;
  assign bus_io.e_b       = b_q;
  assign bus_io.e_imm     = imm_q;
  assign bus_io.e_wn      = wn_q;
  assign bus_io.stall     = stall;
  assign bus_io.stall_cnt = stall_cnt_q;

endmodule
